// File: rtl/pcie_axis_pkg.sv
// pcie_axis_pkg: grant/state encoding and default 64-bit 7-series TX widths shared by the TX AXI-Stream blocks
package pcie_axis_pkg;
  typedef enum logic [1:0] {GNT_NONE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} gnt_e;
  localparam int TX_DATA_WIDTH = 64;
  localparam int TX_KEEP_WIDTH = TX_DATA_WIDTH / 32;
  localparam int TX_USER_WIDTH = 4;
  localparam int PKT_CNT_WIDTH = 16;
endpackage

// File: rtl/axis_skid_buf.sv
// axis_skid_buf: 2-entry registered AXI-Stream slice; s_axis_* in, m_axis_* out from the head entry, s_axis_tready low only when both entries are held
module axis_skid_buf #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = 2,
  parameter int USER_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);
  localparam int W = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;
  logic [W-1:0] ent0, ent1, din;
  logic [1:0] cnt;
  logic push, pop;
  assign din = {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
  assign s_axis_tready = cnt != 2'd2;
  assign m_axis_tvalid = cnt != 2'd0;
  assign push = s_axis_tvalid & s_axis_tready;
  assign pop = m_axis_tvalid & m_axis_tready;
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = ent0;
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      if (pop) ent0 <= (push && cnt == 2'd1) ? din : ent1;
      else if (push && cnt == 2'd0) ent0 <= din;
      if (push && !pop && cnt == 2'd1) ent1 <= din;
    end
endmodule

// File: rtl/axis_tx_pkt_arbiter.sv
// axis_tx_pkt_arbiter: whole-packet arbiter of s0 (completions) and s1 (requests) onto m (core TX) via a skid stage; gated by user_lnk_up/bm_en, saturating pkt_cnt0/1, busy
module axis_tx_pkt_arbiter
  import pcie_axis_pkg::*;
#(
  parameter int DATA_WIDTH = TX_DATA_WIDTH,
  parameter int KEEP_WIDTH = DATA_WIDTH / 32,
  parameter int USER_WIDTH = TX_USER_WIDTH,
  parameter bit RR = 1'b1,
  parameter int CNT_WIDTH = PKT_CNT_WIDTH
) (
  input  logic                  user_clk,
  input  logic                  user_reset,
  input  logic                  user_lnk_up,
  input  logic                  bm_en,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
  input  logic [USER_WIDTH-1:0] s0_axis_tuser,
  input  logic                  s0_axis_tlast,
  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
  input  logic [USER_WIDTH-1:0] s1_axis_tuser,
  input  logic                  s1_axis_tlast,
  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [CNT_WIDTH-1:0]  pkt_cnt0,
  output logic [CNT_WIDTH-1:0]  pkt_cnt1,
  output logic                  busy
);
  gnt_e state, state_nxt;
  logic last_gnt, e0, e1, g0, g1, acc0, acc1, skid_rdy, skid_valid;
  assign e0 = s0_axis_tvalid & user_lnk_up;
  assign e1 = s1_axis_tvalid & user_lnk_up & bm_en;
  assign g0 = state == GNT0;
  assign g1 = state == GNT1;
  assign s0_axis_tready = g0 & skid_rdy;
  assign s1_axis_tready = g1 & skid_rdy;
  assign acc0 = s0_axis_tvalid & s0_axis_tready;
  assign acc1 = s1_axis_tvalid & s1_axis_tready;
  assign skid_valid = (g0 & s0_axis_tvalid) | (g1 & s1_axis_tvalid);
  assign busy = (state != GNT_NONE) | m_axis_tvalid;
  always_comb begin
    state_nxt = state;
    if (state == GNT_NONE)
      state_nxt = (e0 & e1) ? ((RR & !last_gnt) ? GNT1 : GNT0) : e0 ? GNT0 : e1 ? GNT1 : GNT_NONE;
    else if ((acc0 & s0_axis_tlast) | (acc1 & s1_axis_tlast))
      state_nxt = GNT_NONE;
  end
  always_ff @(posedge user_clk)
    if (user_reset) begin
      state <= GNT_NONE;
      last_gnt <= 1'b1;
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      state <= state_nxt;
      if (state == GNT_NONE && state_nxt != GNT_NONE) last_gnt <= state_nxt == GNT1;
      if (acc0 && s0_axis_tlast && !(&pkt_cnt0)) pkt_cnt0 <= pkt_cnt0 + 1'b1;
      if (acc1 && s1_axis_tlast && !(&pkt_cnt1)) pkt_cnt1 <= pkt_cnt1 + 1'b1;
    end
  axis_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .KEEP_WIDTH(KEEP_WIDTH),
    .USER_WIDTH(USER_WIDTH)
  ) u_skid (
    .clk          (user_clk),
    .rst          (user_reset),
    .s_axis_tdata (g1 ? s1_axis_tdata : s0_axis_tdata),
    .s_axis_tkeep (g1 ? s1_axis_tkeep : s0_axis_tkeep),
    .s_axis_tuser (g1 ? s1_axis_tuser : s0_axis_tuser),
    .s_axis_tlast (g1 ? s1_axis_tlast : s0_axis_tlast),
    .s_axis_tvalid(skid_valid),
    .s_axis_tready(skid_rdy),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
  );
endmodule

// File: tb/tb_axis_tx_pkt_arbiter.sv
// tb_axis_tx_pkt_arbiter: randomized scenarios checked against a packet/queue-level reference model
module tb_axis_tx_pkt_arbiter;
  localparam int DW = 64, KW = 2, UW = 4, CW = 5;
  localparam int CMAX = (1 << CW) - 1;
  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic l;
    logic p;
  } beat_t;
  logic user_clk = 1'b0, user_reset = 1'b1, user_lnk_up = 1'b0, bm_en = 1'b0, m_axis_tready = 1'b0;
  logic [DW-1:0] s0_tdata = '0, s1_tdata = '0;
  logic [KW-1:0] s0_tkeep = '0, s1_tkeep = '0;
  logic [UW-1:0] s0_tuser = '0, s1_tuser = '0;
  logic s0_tlast = 1'b0, s1_tlast = 1'b0, s0_tvalid = 1'b0, s1_tvalid = 1'b0;
  logic a_s0r, a_s1r, a_mv, a_ml, a_busy, b_s0r, b_s1r, b_mv, b_ml, b_busy;
  logic [DW-1:0] a_md, b_md;
  logic [KW-1:0] a_mk, b_mk;
  logic [UW-1:0] a_mu, b_mu;
  logic [CW-1:0] a_c0, a_c1, b_c0, b_c1;
  logic o_s0r, o_s1r, o_mv, o_ml, o_busy;
  logic [DW-1:0] o_md;
  logic [KW-1:0] o_mk;
  logic [UW-1:0] o_mu;
  logic [CW-1:0] o_c0, o_c1;
  bit sel = 0;
  always #5 user_clk = ~user_clk;
  axis_tx_pkt_arbiter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .RR(1'b1), .CNT_WIDTH(CW)) dut (
    .user_clk(user_clk), .user_reset(user_reset), .user_lnk_up(user_lnk_up), .bm_en(bm_en),
    .s0_axis_tdata(s0_tdata), .s0_axis_tkeep(s0_tkeep), .s0_axis_tuser(s0_tuser), .s0_axis_tlast(s0_tlast),
    .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(a_s0r),
    .s1_axis_tdata(s1_tdata), .s1_axis_tkeep(s1_tkeep), .s1_axis_tuser(s1_tuser), .s1_axis_tlast(s1_tlast),
    .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(a_s1r),
    .m_axis_tdata(a_md), .m_axis_tkeep(a_mk), .m_axis_tuser(a_mu), .m_axis_tlast(a_ml),
    .m_axis_tvalid(a_mv), .m_axis_tready(m_axis_tready),
    .pkt_cnt0(a_c0), .pkt_cnt1(a_c1), .busy(a_busy)
  );
  axis_tx_pkt_arbiter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .RR(1'b0), .CNT_WIDTH(CW)) dut_fp (
    .user_clk(user_clk), .user_reset(user_reset), .user_lnk_up(user_lnk_up), .bm_en(bm_en),
    .s0_axis_tdata(s0_tdata), .s0_axis_tkeep(s0_tkeep), .s0_axis_tuser(s0_tuser), .s0_axis_tlast(s0_tlast),
    .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(b_s0r),
    .s1_axis_tdata(s1_tdata), .s1_axis_tkeep(s1_tkeep), .s1_axis_tuser(s1_tuser), .s1_axis_tlast(s1_tlast),
    .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(b_s1r),
    .m_axis_tdata(b_md), .m_axis_tkeep(b_mk), .m_axis_tuser(b_mu), .m_axis_tlast(b_ml),
    .m_axis_tvalid(b_mv), .m_axis_tready(m_axis_tready),
    .pkt_cnt0(b_c0), .pkt_cnt1(b_c1), .busy(b_busy)
  );
  always_comb begin
    {o_s0r, o_s1r, o_mv, o_ml, o_busy} = sel ? {b_s0r, b_s1r, b_mv, b_ml, b_busy} : {a_s0r, a_s1r, a_mv, a_ml, a_busy};
    {o_md, o_mk, o_mu, o_c0, o_c1} = sel ? {b_md, b_mk, b_mu, b_c0, b_c1} : {a_md, a_mk, a_mu, a_c0, a_c1};
  end

  beat_t src0[$], src1[$], fifo[$];
  int out_ports[$];
  int owner = -1, cnt0 = 0, cnt1 = 0, acc_total = 0, checks = 0, errors = 0;
  int pv = 100, pmr = 100;
  bit last_gnt = 1, v0 = 0, v1 = 0, drop_bm = 0, rand_gate = 0;

  task automatic clear_model();
    src0.delete(); src1.delete(); fifo.delete(); out_ports.delete();
    owner = -1; last_gnt = 1; cnt0 = 0; cnt1 = 0; v0 = 0; v1 = 0; drop_bm = 0;
    s0_tvalid = 0; s1_tvalid = 0;
  endtask

  task automatic do_reset();
    user_reset = 1; m_axis_tready = 0;
    clear_model();
    @(posedge user_clk); @(negedge user_clk);
    user_reset = 0;
  endtask

  task automatic make_pkt(input bit p, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = {$urandom, $urandom}; b.k = KW'($urandom); b.u = UW'($urandom);
      b.l = (i == len - 1); b.p = p;
      if (p) src1.push_back(b); else src0.push_back(b);
    end
  endtask

  task automatic step();
    beat_t b, h;
    bit x0, x1, e0, e1;
    if (rand_gate) begin
      user_lnk_up = $urandom_range(99) < 85;
      bm_en = $urandom_range(99) < 85;
    end
    if (!v0) v0 = src0.size() > 0 && $urandom_range(99) < pv;
    if (!v1) v1 = src1.size() > 0 && $urandom_range(99) < pv;
    s0_tvalid = v0; s1_tvalid = v1;
    if (v0) {s0_tdata, s0_tkeep, s0_tuser, s0_tlast} = {src0[0].d, src0[0].k, src0[0].u, src0[0].l};
    if (v1) {s1_tdata, s1_tkeep, s1_tuser, s1_tlast} = {src1[0].d, src1[0].k, src1[0].u, src1[0].l};
    m_axis_tready = $urandom_range(99) < pmr;
    #1;
    x0 = owner == 0 && fifo.size() < 2;
    x1 = owner == 1 && fifo.size() < 2;
    checks++;
    if (o_s0r !== x0) begin errors++; $display("FAIL s0_tready got %b exp %b t=%0t", o_s0r, x0, $time); end
    checks++;
    if (o_s1r !== x1) begin errors++; $display("FAIL s1_tready got %b exp %b t=%0t", o_s1r, x1, $time); end
    checks++;
    if (o_mv !== (fifo.size() > 0)) begin errors++; $display("FAIL m_tvalid got %b exp %b t=%0t", o_mv, fifo.size() > 0, $time); end
    if (fifo.size() > 0) begin
      h = fifo[0];
      checks++;
      if ({o_md, o_mk, o_mu, o_ml} !== {h.d, h.k, h.u, h.l}) begin
        errors++; $display("FAIL m_beat got %h exp %h t=%0t", {o_md, o_mk, o_mu, o_ml}, {h.d, h.k, h.u, h.l}, $time);
      end
    end
    checks++;
    if (o_busy !== (owner >= 0 || fifo.size() > 0)) begin errors++; $display("FAIL busy got %b exp %b t=%0t", o_busy, owner >= 0 || fifo.size() > 0, $time); end
    checks++;
    if ({o_c0, o_c1} !== {cnt0[CW-1:0], cnt1[CW-1:0]}) begin
      errors++; $display("FAIL pkt_cnt got %0d/%0d exp %0d/%0d t=%0t", o_c0, o_c1, cnt0, cnt1, $time);
    end
    x0 = x0 && v0;
    x1 = x1 && v1;
    if (fifo.size() > 0 && m_axis_tready) begin
      h = fifo.pop_front();
      if (h.l) out_ports.push_back(int'(h.p));
    end
    if (owner < 0) begin
      e0 = v0 && user_lnk_up;
      e1 = v1 && user_lnk_up && bm_en;
      if (e0 && e1) owner = (!sel && !last_gnt) ? 1 : 0;
      else if (e0) owner = 0;
      else if (e1) owner = 1;
      if (owner >= 0) last_gnt = owner[0];
    end else if (x0 || x1) begin
      if (x0) begin b = src0.pop_front(); v0 = 0; end
      else begin b = src1.pop_front(); v1 = 0; end
      fifo.push_back(b);
      acc_total++;
      if (b.l && !b.p && cnt0 < CMAX) cnt0++;
      if (b.l && b.p && cnt1 < CMAX) cnt1++;
      if (b.l) owner = -1;
      if (drop_bm && b.p && !b.l) bm_en = 0;
    end
    @(posedge user_clk); @(negedge user_clk);
  endtask

  task automatic run(input int maxc, input string nm);
    int n = 0;
    while ((src0.size() > 0 || src1.size() > 0 || fifo.size() > 0 || owner >= 0) && n < maxc) begin
      step();
      n++;
    end
    checks++;
    if (n >= maxc) begin errors++; $display("FAIL %s drain got %0d cycles exp <%0d", nm, n, maxc); end
  endtask

  task automatic test_reset();
    clear_model();
    user_reset = 1; user_lnk_up = 1; bm_en = 1; m_axis_tready = 1; s0_tvalid = 1; s1_tvalid = 1;
    repeat (3) @(negedge user_clk);
    checks++;
    if (o_mv !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", o_mv); end
    checks++;
    if ({o_md, o_mk, o_mu, o_ml} !== '0) begin errors++; $display("FAIL reset_mdata got %h exp 0", {o_md, o_mk, o_mu, o_ml}); end
    checks++;
    if ({o_s0r, o_s1r} !== 2'b00) begin errors++; $display("FAIL reset_tready got %b exp 00", {o_s0r, o_s1r}); end
    checks++;
    if ({o_c0, o_c1} !== '0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", o_c0, o_c1); end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    s0_tvalid = 0; s1_tvalid = 0; user_reset = 0;
  endtask

  task automatic test_single();
    pv = 100; pmr = 100;
    make_pkt(0, 3);
    run(50, "single");
    checks++;
    if (o_c0 !== CW'(1)) begin errors++; $display("FAIL single_cnt0 got %0d exp 1", o_c0); end
    checks++;
    if (out_ports.size() != 1) begin errors++; $display("FAIL single_pkts got %0d exp 1", out_ports.size()); end
  endtask

  task automatic test_rr_tie();
    do_reset();
    pv = 100; pmr = 100;
    for (int i = 0; i < 4; i++) begin make_pkt(0, 2); make_pkt(1, 2); end
    run(200, "rr_tie");
    checks++;
    if (out_ports.size() != 8) begin errors++; $display("FAIL rr_pkts got %0d exp 8", out_ports.size()); end
    for (int i = 0; i < out_ports.size(); i++) begin
      checks++;
      if (out_ports[i] != i % 2) begin errors++; $display("FAIL rr_order[%0d] got %0d exp %0d", i, out_ports[i], i % 2); end
    end
    checks++;
    if ({o_c0, o_c1} !== {CW'(4), CW'(4)}) begin errors++; $display("FAIL rr_cnt got %0d/%0d exp 4/4", o_c0, o_c1); end
  endtask

  task automatic test_fixed_prio();
    sel = 1;
    do_reset();
    pv = 100; pmr = 100;
    for (int i = 0; i < 3; i++) make_pkt(0, 2);
    for (int i = 0; i < 2; i++) make_pkt(1, 2);
    run(200, "fixed_prio");
    checks++;
    if (out_ports.size() != 5) begin errors++; $display("FAIL fp_pkts got %0d exp 5", out_ports.size()); end
    for (int i = 0; i < out_ports.size(); i++) begin
      checks++;
      if (out_ports[i] != (i < 3 ? 0 : 1)) begin errors++; $display("FAIL fp_order[%0d] got %0d exp %0d", i, out_ports[i], i < 3 ? 0 : 1); end
    end
    sel = 0;
  endtask

  task automatic test_gating_bm();
    do_reset();
    bm_en = 0; pv = 100; pmr = 100;
    make_pkt(1, 2); make_pkt(0, 2);
    repeat (20) step();
    checks++;
    if ({o_c0, o_c1} !== {CW'(1), CW'(0)}) begin errors++; $display("FAIL bm_gate_cnt got %0d/%0d exp 1/0", o_c0, o_c1); end
    bm_en = 1;
    run(50, "bm_gate");
    checks++;
    if (o_c1 !== CW'(1)) begin errors++; $display("FAIL bm_release_cnt1 got %0d exp 1", o_c1); end
  endtask

  task automatic test_bm_drop();
    do_reset();
    bm_en = 1; pv = 100; pmr = 100; drop_bm = 1;
    make_pkt(1, 4); make_pkt(1, 2);
    repeat (30) step();
    checks++;
    if (o_c1 !== CW'(1)) begin errors++; $display("FAIL bm_drop_cnt1 got %0d exp 1", o_c1); end
    checks++;
    if ({o_busy, o_s1r} !== 2'b00) begin errors++; $display("FAIL bm_drop_hold got busy/tready %b exp 00", {o_busy, o_s1r}); end
    drop_bm = 0; bm_en = 1;
    run(50, "bm_drop");
    checks++;
    if (o_c1 !== CW'(2)) begin errors++; $display("FAIL bm_drop_cnt1_final got %0d exp 2", o_c1); end
  endtask

  task automatic test_link_down();
    do_reset();
    user_lnk_up = 0; bm_en = 1; pv = 100; pmr = 100;
    make_pkt(0, 2); make_pkt(1, 2);
    repeat (20) step();
    checks++;
    if ({o_c0, o_c1, o_mv} !== {CW'(0), CW'(0), 1'b0}) begin errors++; $display("FAIL lnk_down got cnt %0d/%0d tvalid %b exp 0/0 0", o_c0, o_c1, o_mv); end
    user_lnk_up = 1;
    run(50, "lnk_down");
    checks++;
    if ({o_c0, o_c1} !== {CW'(1), CW'(1)}) begin errors++; $display("FAIL lnk_up_cnt got %0d/%0d exp 1/1", o_c0, o_c1); end
  endtask

  task automatic test_backpressure();
    int n0 = 0, n1 = 0;
    bit p;
    do_reset();
    pv = 70; pmr = 50; rand_gate = 1;
    for (int i = 0; i < 100; i++) begin
      p = 1'($urandom);
      make_pkt(p, $urandom_range(1, 5));
      if (p) n1++; else n0++;
    end
    run(20000, "backpressure");
    rand_gate = 0; user_lnk_up = 1; bm_en = 1;
    checks++;
    if ({o_c0, o_c1} !== {CW'(n0 > CMAX ? CMAX : n0), CW'(n1 > CMAX ? CMAX : n1)}) begin
      errors++; $display("FAIL bp_cnt got %0d/%0d exp %0d/%0d (saturating at %0d)", o_c0, o_c1, n0, n1, CMAX);
    end
    checks++;
    if (out_ports.size() != 100) begin errors++; $display("FAIL bp_pkts got %0d exp 100", out_ports.size()); end
  endtask

  task automatic test_reset_mid();
    int a = acc_total;
    pv = 100; pmr = 100; out_ports.delete();
    make_pkt(0, 4);
    for (int n = 0; n < 50 && acc_total < a + 2; n++) step();
    checks++;
    if (acc_total < a + 2) begin errors++; $display("FAIL reset_mid_start got %0d beats exp 2", acc_total - a); end
    user_reset = 1;
    @(posedge user_clk); @(negedge user_clk);
    checks++;
    if (o_mv !== 1'b0) begin errors++; $display("FAIL reset_mid_tvalid got %b exp 0", o_mv); end
    checks++;
    if ({o_c0, o_c1} !== '0) begin errors++; $display("FAIL reset_mid_cnt got %0d/%0d exp 0/0", o_c0, o_c1); end
    checks++;
    if ({o_busy, o_s0r} !== 2'b00) begin errors++; $display("FAIL reset_mid_idle got busy/tready %b exp 00", {o_busy, o_s0r}); end
    user_reset = 0;
    clear_model();
    make_pkt(0, 4);
    run(50, "reset_mid_fresh");
    checks++;
    if (o_c0 !== CW'(1)) begin errors++; $display("FAIL reset_mid_fresh_cnt got %0d exp 1", o_c0); end
    checks++;
    if (out_ports.size() != 1) begin errors++; $display("FAIL reset_mid_fresh_pkts got %0d exp 1", out_ports.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_tie();
    test_fixed_prio();
    test_gating_bm();
    test_bm_drop();
    test_link_down();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_tx_pkt_arbiter.md
# axis_tx_pkt_arbiter

Packet-level arbiter that shares the PCIe core's single TX AXI-Stream port between two TLP sources. Port 0 carries completions from the TLP-to-AL bridge; port 1 carries requester TLPs (memory writes, DMA). The arbiter grants whole packets only, never interleaving beats. It gates new grants on link-up, and gates port 1 on bus-master enable. A registered skid stage feeds the core's `s_axis_tx_*`. Per-port packet counters are kept for debug.

## Interface
Parameters:
- `DATA_WIDTH`, 64 — TX data width.
- `KEEP_WIDTH`, `DATA_WIDTH/32` — dword-granular keep (2 at 64 bit); the top level expands it to byte keep.
- `USER_WIDTH`, 4 — `tuser` width, passed through per beat.
- `RR`, 1 — 1 = round-robin; 0 = fixed priority with port 0 highest.
- `CNT_WIDTH`, 16 — width of the packet counters.

Ports:
- `user_clk` in 1 — the only clock.
- `user_reset` in 1 — synchronous, active-high reset.
- `user_lnk_up` in 1 — link up; a new grant is allowed only while this is high.
- `bm_en` in 1 — bus-master enable; port 1 is eligible only while this is high.
- `s0_axis_tdata/tkeep/tuser/tlast/tvalid` in DATA_WIDTH/KEEP_WIDTH/USER_WIDTH/1/1 — port 0 (completions).
- `s0_axis_tready` out 1 — port 0 ready.
- `s1_axis_tdata/tkeep/tuser/tlast/tvalid` in (same widths) — port 1 (requests).
- `s1_axis_tready` out 1 — port 1 ready.
- `m_axis_tdata/tkeep/tuser/tlast/tvalid` out (same widths) — to the core TX port.
- `m_axis_tready` in 1 — core TX ready.
- `pkt_cnt0`, `pkt_cnt1` out CNT_WIDTH — packets accepted per port; saturating.
- `busy` out 1 — high while a grant is held or the skid stage holds data.

## Operation
- FSM states: IDLE, GNT0, GNT1. State reg resets to IDLE.
- Eligibility: `e0 = s0_tvalid & user_lnk_up`; `e1 = s1_tvalid & user_lnk_up & bm_en`.
- In IDLE with any eligible port:
  - Winner goes to GNTx at the next edge.
  - Only one eligible port: that port wins.
  - Both eligible, RR=1: the port not in `last_gnt` wins.
  - Both eligible, RR=0: port 0 wins.
  - `last_gnt` resets to 1, so port 0 wins the first tie.
  - `last_gnt` updates on entry to GNTx.
- In GNTx: `sx_tready = !skid_full`; the other port's `tready` = 0.
- In IDLE: both `tready` = 0.
- An accepted beat with `tlast` = 1 returns the FSM to IDLE. This costs one idle cycle between packets.
- `user_lnk_up` or `bm_en` falling mid-packet does not break the grant. The packet drains to `tlast`, and the condition applies at the next arbitration.
- `tvalid` dropping mid-packet holds the grant; the arbiter waits.
- Skid stage:
  - 2-entry, registered.
  - `skid_full` = 2 entries occupied.
  - `m_axis_*` driven from the head entry.
  - A simultaneous push and pop keeps occupancy unchanged.
- Counters:
  - `pkt_cntX` increments on each accepted input beat of port X with `tlast` = 1.
  - Holds at all-ones (saturating).
- Data, keep, tuser and tlast are never modified.

## Timing
- Reset values:
  - `m_axis_tvalid` = 0; all other `m_axis_*` = 0.
  - Both `tready` = 0.
  - `pkt_cnt0` = `pkt_cnt1` = 0; `busy` = 0; state = IDLE.
- Latency:
  - A request seen in IDLE at edge N gives `tready` high in cycle N+1.
  - A beat accepted at edge M is on `m_axis_*` from M+1.
- Throughput: 1 beat/cycle while `m_axis_tready` = 1.
- Backpressure:
  - `m_axis_tready` low fills the skid buffer; input `tready` drops the cycle after occupancy reaches 2.
  - No beat is lost or duplicated.
- `m_axis_tvalid`, once high, stays high with stable data until accepted.
- Reset mid-packet:
  - Skid buffer is flushed and the FSM returns to IDLE.
  - `m_axis_tvalid` = 0 from the cycle after reset is sampled.
  - Sources share the reset, so no resync is needed.

## Structure
- Shared package `pcie_axis_pkg`:
  - Grant encoding (`GNT_NONE`, `GNT0`, `GNT1`).
  - Default widths for 64-bit 7-series TX.
- One sub-module `axis_skid_buf`: a 2-entry AXI-Stream register slice parameterised on DATA/KEEP/USER width. It is reusable on the RX side.
- Arbiter FSM, eligibility logic and counters live in the top of this block.

## Test plan
- Single source: port 0 sends a 3-beat packet with `m_axis_tready` = 1.
  - Beats appear on `m` one cycle after acceptance, in order.
  - `pkt_cnt0` = 1; port 1 `tready` stays 0 throughout.
- Tie, RR=1: both ports present 2-beat packets back-to-back, 4 each.
  - Output order is 0,1,0,1,0,1,0,1 at packet granularity, never interleaved.
  - Final counts are 4/4.
- Tie, RR=0: both ports are continuously valid.
  - Port 1 is granted only when `s0_tvalid` is low in IDLE.
- Gating:
  - With `bm_en` = 0, a port-1 request is never granted.
  - `bm_en` falling mid port-1 packet: the packet still completes; the next port-1 packet is held.
  - With `user_lnk_up` = 0, no grant is made.
- Backpressure: toggle `m_axis_tready` randomly over 100 packets.
  - The scoreboard sees an exact match; `tvalid`/data stay stable while stalled.
  - Input `tready` = 0 whenever 2 entries are held.
- Reset mid-packet: assert `user_reset` on beat 2 of 4.
  - Next cycle: `m_axis_tvalid` = 0, counters = 0, state IDLE.
  - A fresh packet afterwards passes intact.
